// File: rtl/bcd_search_ctrl.sv
// BCD linear search controller: counts a 4-digit BCD value up from 0000
// until it reaches a latched BCD target, then reports HIT (or ERR when the
// target contains a non-BCD digit).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for START; Q holds last result
// ST_RUN  | counting Q up in BCD until Q reaches latched target
// ST_HIT  | Q equals target; DONE high until ACK (or AUTO_ACK)
// ST_ERR  | target had a digit > 9; ERR high until ACK (or AUTO_ACK)
module bcd_search_ctrl #(
  parameter bit AUTO_ACK = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ACK,
  input  logic [3:0] V1000,
  input  logic [3:0] V0100,
  input  logic [3:0] V0010,
  input  logic [3:0] V0001,
  output logic [3:0] Q1000,
  output logic [3:0] Q0100,
  output logic [3:0] Q0010,
  output logic [3:0] Q0001,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] q1000_q, q0100_q, q0010_q, q0001_q;
  logic [3:0] q1000_d, q0100_d, q0010_d, q0001_d;
  logic [3:0] v1000_q, v0100_q, v0010_q, v0001_q;
  logic [3:0] v1000_d, v0100_d, v0010_d, v0001_d;

  logic [3:0]  inc1000, inc0100, inc0010, inc0001;
  logic        cy0001, cy0010, cy0100;
  logic [13:0] target_val, count_val;
  logic        hit, v_valid, ack_eff;

  // BCD increment of the count, digit carries ripple units -> thousands
  always_comb begin
    cy0001  = (q0001_q == 4'd9);
    cy0010  = cy0001 && (q0010_q == 4'd9);
    cy0100  = cy0010 && (q0100_q == 4'd9);
    inc0001 = cy0001 ? 4'd0 : q0001_q + 4'd1;
    inc0010 = cy0001 ? ((q0010_q == 4'd9) ? 4'd0 : q0010_q + 4'd1) : q0010_q;
    inc0100 = cy0010 ? ((q0100_q == 4'd9) ? 4'd0 : q0100_q + 4'd1) : q0100_q;
    inc1000 = cy0100 ? q1000_q + 4'd1 : q1000_q;
  end

  // Binary weight of target and count; both stay <= 9999 so 14 bits suffice
  always_comb begin
    target_val = {10'd0, v1000_q} * 14'd1000 + {10'd0, v0100_q} * 14'd100
               + {10'd0, v0010_q} * 14'd10   + {10'd0, v0001_q};
    count_val  = {10'd0, q1000_q} * 14'd1000 + {10'd0, q0100_q} * 14'd100
               + {10'd0, q0010_q} * 14'd10   + {10'd0, q0001_q};
    hit        = (target_val <= count_val);
    v_valid    = (V1000 <= 4'd9) && (V0100 <= 4'd9) &&
                 (V0010 <= 4'd9) && (V0001 <= 4'd9);
    ack_eff    = ACK || AUTO_ACK;
  end

  // Next-state, count and target-latch logic
  always_comb begin
    state_d = state_q;
    q1000_d = q1000_q;
    q0100_d = q0100_q;
    q0010_d = q0010_q;
    q0001_d = q0001_q;
    v1000_d = v1000_q;
    v0100_d = v0100_q;
    v0010_d = v0010_q;
    v0001_d = v0001_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = v_valid ? ST_RUN : ST_ERR;
          q1000_d = 4'd0;
          q0100_d = 4'd0;
          q0010_d = 4'd0;
          q0001_d = 4'd0;
          v1000_d = V1000;
          v0100_d = V0100;
          v0010_d = V0010;
          v0001_d = V0001;
        end
      end
      ST_RUN: begin
        if (hit) begin
          state_d = ST_HIT;
        end else begin
          q1000_d = inc1000;
          q0100_d = inc0100;
          q0010_d = inc0010;
          q0001_d = inc0001;
        end
      end
      ST_HIT:  if (ack_eff) state_d = ST_IDLE;
      ST_ERR:  if (ack_eff) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, count and latched-target registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      q1000_q <= 4'd0;
      q0100_q <= 4'd0;
      q0010_q <= 4'd0;
      q0001_q <= 4'd0;
      v1000_q <= 4'd0;
      v0100_q <= 4'd0;
      v0010_q <= 4'd0;
      v0001_q <= 4'd0;
    end else begin
      state_q <= state_d;
      q1000_q <= q1000_d;
      q0100_q <= q0100_d;
      q0010_q <= q0010_d;
      q0001_q <= q0001_d;
      v1000_q <= v1000_d;
      v0100_q <= v0100_d;
      v0010_q <= v0010_d;
      v0001_q <= v0001_d;
    end
  end

  assign Q1000 = q1000_q;
  assign Q0100 = q0100_q;
  assign Q0010 = q0010_q;
  assign Q0001 = q0001_q;
  assign BUSY  = (state_q == ST_RUN);
  assign DONE  = (state_q == ST_HIT);
  assign ERR   = (state_q == ST_ERR);

endmodule

// File: tb/tb_bcd_search_ctrl.sv
// Directed testbench for bcd_search_ctrl (manual-ack and auto-ack instances).
module tb_bcd_search_ctrl;

  logic       CLK = 1'b0;
  logic       RST, START, ACK, START2;
  logic [3:0] V1000, V0100, V0010, V0001;
  logic [3:0] Q1000, Q0100, Q0010, Q0001;
  logic       BUSY, DONE, ERR;
  logic [3:0] R1000, R0100, R0010, R0001;
  logic       BUSY2, DONE2, ERR2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bcd_search_ctrl #(.AUTO_ACK(1'b0)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ACK(ACK),
    .V1000(V1000), .V0100(V0100), .V0010(V0010), .V0001(V0001),
    .Q1000(Q1000), .Q0100(Q0100), .Q0010(Q0010), .Q0001(Q0001),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  bcd_search_ctrl #(.AUTO_ACK(1'b1)) dut_auto (
    .CLK(CLK), .RST(RST), .START(START2), .ACK(ACK),
    .V1000(V1000), .V0100(V0100), .V0010(V0010), .V0001(V0001),
    .Q1000(R1000), .Q0100(R0100), .Q0010(R0010), .Q0001(R0001),
    .BUSY(BUSY2), .DONE(DONE2), .ERR(ERR2)
  );

  function automatic logic [15:0] to_bcd(input int n);
    to_bcd = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] q_now();
    q_now = {Q1000, Q0100, Q0010, Q0001};
  endfunction

  task automatic set_v(input int n);
    {V1000, V0100, V0010, V0001} = to_bcd(n);
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; START2 = 1'b0; ACK = 1'b0;
    set_v(0);
    #3;
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b000 || q_now() !== 16'h0000) begin
      errors++;
      $display("FAIL reset: bde=%b q=%h, required bde=000 q=0000", {BUSY, DONE, ERR}, q_now());
    end
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b000 || q_now() !== 16'h0000) begin
      errors++;
      $display("FAIL reset_idle: bde=%b q=%h, required bde=000 q=0000", {BUSY, DONE, ERR}, q_now());
    end
  endtask

  // Full search with per-cycle trace of Q and flags, then ACK back to IDLE
  task automatic test_search(input int n, input bit change_mid, input string tag);
    bit bad = 1'b0;
    @(negedge CLK);
    set_v(n); START = 1'b1; ACK = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || DONE !== 1'b0 || q_now() !== 16'h0000) begin
      errors++;
      $display("FAIL %s_start: busy=%b done=%b q=%h, required busy=1 done=0 q=0000", tag, BUSY, DONE, q_now());
    end
    if (change_mid) set_v(0);
    for (int k = 1; k <= n; k++) begin
      @(negedge CLK);
      if (BUSY !== 1'b1 || DONE !== 1'b0 || ERR !== 1'b0 || q_now() !== to_bcd(k)) begin
        if (!bad)
          $display("FAIL %s_trace: cycle %0d bde=%b q=%h, required bde=100 q=%h", tag, k, {BUSY, DONE, ERR}, q_now(), to_bcd(k));
        bad = 1'b1;
      end
    end
    checks++;
    if (bad) errors++;
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b010 || q_now() !== to_bcd(n)) begin
      errors++;
      $display("FAIL %s_done: bde=%b q=%h, required bde=010 q=%h", tag, {BUSY, DONE, ERR}, q_now(), to_bcd(n));
    end
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b010 || q_now() !== to_bcd(n)) begin
      errors++;
      $display("FAIL %s_hold: bde=%b q=%h, required bde=010 q=%h", tag, {BUSY, DONE, ERR}, q_now(), to_bcd(n));
    end
    ACK = 1'b1;
    @(negedge CLK);
    ACK = 1'b0;
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b000 || q_now() !== to_bcd(n)) begin
      errors++;
      $display("FAIL %s_ack: bde=%b q=%h, required bde=000 q=%h", tag, {BUSY, DONE, ERR}, q_now(), to_bcd(n));
    end
  endtask

  task automatic test_err();
    @(negedge CLK);
    V1000 = 4'd0; V0100 = 4'd0; V0010 = 4'hA; V0001 = 4'd0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b001 || q_now() !== 16'h0000) begin
      errors++;
      $display("FAIL err_enter: bde=%b q=%h, required bde=001 q=0000", {BUSY, DONE, ERR}, q_now());
    end
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b001) begin
      errors++;
      $display("FAIL err_hold: bde=%b, required bde=001", {BUSY, DONE, ERR});
    end
    set_v(7);
    START = 1'b1; ACK = 1'b1;
    @(negedge CLK);
    START = 1'b0; ACK = 1'b0;
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b000 || q_now() !== 16'h0000) begin
      errors++;
      $display("FAIL err_start_ack: bde=%b q=%h, required bde=000 q=0000", {BUSY, DONE, ERR}, q_now());
    end
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b000) begin
      errors++;
      $display("FAIL err_not_queued: bde=%b, required bde=000", {BUSY, DONE, ERR});
    end
  endtask

  // START/ACK held during RUN are ignored; START+ACK in HIT only returns to IDLE
  task automatic test_ignore();
    @(negedge CLK);
    set_v(5); START = 1'b1;
    @(negedge CLK);
    ACK = 1'b1;
    repeat (3) @(negedge CLK);
    START = 1'b0; ACK = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || q_now() !== 16'h0003) begin
      errors++;
      $display("FAIL ignore_run: busy=%b q=%h, required busy=1 q=0003", BUSY, q_now());
    end
    repeat (3) @(negedge CLK);
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b010 || q_now() !== 16'h0005) begin
      errors++;
      $display("FAIL ignore_done: bde=%b q=%h, required bde=010 q=0005", {BUSY, DONE, ERR}, q_now());
    end
    START = 1'b1; ACK = 1'b1;
    @(negedge CLK);
    START = 1'b0; ACK = 1'b0;
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b000 || q_now() !== 16'h0005) begin
      errors++;
      $display("FAIL ignore_hit_start: bde=%b q=%h, required bde=000 q=0005", {BUSY, DONE, ERR}, q_now());
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    set_v(1234); START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (500) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1 || q_now() !== 16'h0500) begin
      errors++;
      $display("FAIL rst_mid_pre: busy=%b q=%h, required busy=1 q=0500", BUSY, q_now());
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b000 || q_now() !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_async: bde=%b q=%h, required bde=000 q=0000", {BUSY, DONE, ERR}, q_now());
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b000 || q_now() !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_idle: bde=%b q=%h, required bde=000 q=0000", {BUSY, DONE, ERR}, q_now());
    end
  endtask

  task automatic test_first_edge();
    @(negedge CLK);
    RST = 1'b1; set_v(2); START = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || q_now() !== 16'h0000) begin
      errors++;
      $display("FAIL first_edge: busy=%b q=%h, required busy=1 q=0000", BUSY, q_now());
    end
    repeat (3) @(negedge CLK);
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b010 || q_now() !== 16'h0002) begin
      errors++;
      $display("FAIL first_edge_done: bde=%b q=%h, required bde=010 q=0002", {BUSY, DONE, ERR}, q_now());
    end
    ACK = 1'b1;
    @(negedge CLK);
    ACK = 1'b0;
  endtask

  task automatic test_auto_ack();
    @(negedge CLK);
    set_v(3); START2 = 1'b1;
    @(negedge CLK);
    START2 = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({BUSY2, DONE2, ERR2} !== 3'b100 || {R1000, R0100, R0010, R0001} !== 16'h0003) begin
      errors++;
      $display("FAIL auto_run: bde=%b q=%h, required bde=100 q=0003", {BUSY2, DONE2, ERR2}, {R1000, R0100, R0010, R0001});
    end
    @(negedge CLK);
    checks++;
    if ({BUSY2, DONE2, ERR2} !== 3'b010 || {R1000, R0100, R0010, R0001} !== 16'h0003) begin
      errors++;
      $display("FAIL auto_done: bde=%b q=%h, required bde=010 q=0003", {BUSY2, DONE2, ERR2}, {R1000, R0100, R0010, R0001});
    end
    @(negedge CLK);
    checks++;
    if ({BUSY2, DONE2, ERR2} !== 3'b000 || {R1000, R0100, R0010, R0001} !== 16'h0003) begin
      errors++;
      $display("FAIL auto_idle: bde=%b q=%h, required bde=000 q=0003", {BUSY2, DONE2, ERR2}, {R1000, R0100, R0010, R0001});
    end
  endtask

  initial begin
    test_reset();
    test_search(1234, 1'b0, "v1234");
    test_search(0, 1'b0, "v0000");
    test_search(109, 1'b0, "v0109");
    test_err();
    test_ignore();
    test_search(9999, 1'b1, "v9999");
    test_reset_mid();
    test_first_edge();
    test_auto_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Flags of both instances must stay mutually exclusive while out of reset
  always @(negedge CLK) begin
    if (!RST && ($countones({BUSY, DONE, ERR}) > 1 || $countones({BUSY2, DONE2, ERR2}) > 1)) begin
      checks++;
      errors++;
      $display("FAIL onehot: bde=%b bde2=%b, required at most one set", {BUSY, DONE, ERR}, {BUSY2, DONE2, ERR2});
    end
  end

endmodule

// File: doc/bcd_search_ctrl.md
BCD_SEARCH_CTRL -- requirements
Module: bcd_search_ctrl

Interface
REQ-001 SHALL have parameter AUTO_ACK, default 0: 1 = leave HIT or ERR after one cycle without ACK.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port START  input  1  request a search; sampled only in IDLE.
REQ-005 SHALL have port ACK  input  1  acknowledge DONE/ERR; sampled only in HIT or ERR.
REQ-006 SHALL have ports V1000, V0100, V0010, V0001  input  4 each  BCD target digits (thousands..units).
REQ-007 SHALL have ports Q1000, Q0100, Q0010, Q0001  output  4 each  registered BCD search count.
REQ-008 SHALL have port BUSY  output  1  high in RUN.
REQ-009 SHALL have port DONE  output  1  high in HIT.
REQ-010 SHALL have port ERR  output  1  high in ERR.

Function
REQ-011 SHALL implement exactly four states: IDLE, RUN, HIT, ERR; BUSY/DONE/ERR decoded from state only.
REQ-012 SHALL latch the four V digits into internal registers at the edge START is accepted; later V changes do not affect the search.
REQ-013 IDLE + START=1 + all V digits <= 9: go to RUN, Q <= 0000, V latched.
REQ-014 IDLE + START=1 + any V digit > 9: go to ERR, Q <= 0000; no search performed.
REQ-015 IDLE + START=0: stay in IDLE, Q holds.
REQ-016 SHALL compute the hit condition combinationally as weighted value of latched V <= weighted value of Q, weights 1000/100/10/1, with 14-bit unsigned arithmetic (max 9999, no overflow).
REQ-017 RUN + hit: go to HIT at the next edge, Q holds (Q equals target value).
REQ-018 RUN + no hit: stay in RUN, Q <= Q+1 in BCD: units 9->0 carries to tens, tens 9->0 to hundreds, hundreds 9->0 to thousands.
REQ-019 Q SHALL always hold valid BCD digits; since the latched target is <= 9999, Q SHALL never pass 9999 and never wrap.
REQ-020 Latency: START accepted at edge t0 with target value N -> DONE rises at edge t0+N+1; BUSY high from edge t0 to edge t0+N+1.
REQ-021 HIT: DONE=1, Q holds result; ACK=1 (or AUTO_ACK=1) -> IDLE at next edge, Q holds until next accepted START.
REQ-022 ERR: ERR=1, Q=0000; ACK=1 (or AUTO_ACK=1) -> IDLE at next edge.
REQ-023 START outside IDLE SHALL be ignored and not queued, including START and ACK together in HIT/ERR.
REQ-024 ACK outside HIT/ERR SHALL be ignored.
REQ-025 At most one of BUSY, DONE, ERR SHALL be high in any cycle.

Reset
REQ-026 RST=1 SHALL immediately, without a clock edge, force state IDLE, Q digits 0000, latched V 0000, BUSY=DONE=ERR=0.
REQ-027 RST asserted during RUN, HIT or ERR SHALL abandon the operation; after release, the block waits in IDLE for a new START.
REQ-028 The first edge after RST deasserts SHALL be treated as a normal IDLE cycle (START accepted if high).

Verification
REQ-029 V=1234, START pulse at edge t0 -> BUSY t0..t0+1235, DONE at edge t0+1235, Q=1,2,3,4; ACK -> IDLE next edge.
REQ-030 V=0000, START at t0 -> DONE at edge t0+1, Q=0000, BUSY high exactly one cycle.
REQ-031 V=0109 -> Q passes 0099->0100 and 0109 without invalid digits; DONE with Q=0,1,0,9 at edge t0+110.
REQ-032 V=9999 -> DONE at edge t0+10000, Q=9,9,9,9, no wrap; V changed to 0000 mid-run has no effect.
REQ-033 V0010=4'hA, START -> ERR next edge, Q=0000, BUSY never high; START+ACK together -> IDLE, START not taken.
REQ-034 RST pulse mid-RUN at Q=0500 -> Q=0000, BUSY=0 immediately; AUTO_ACK=1 run with V=0003 -> DONE one cycle, then IDLE.
